// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage between EX and WB
//
// Purpose: registers the instruction leaving EX, runs LOAD/STORE accesses over
// a req/ack data bus with byte lanes and sign/zero extension, stalls upstream
// while an access waits for ack, and drives the writeback register pair.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   opcode_EX/funct3_EX  instruction class and width/sign select from EX
//   rd_EX/res_EX/x2_EX   destination, result-or-address, store data from EX
//   trap_EX              EX trap: the instruction enters MEM as a bubble
//   stall                freeze upstream stages while an access is waiting
//   d_req/d_we/d_addr/d_be/d_wdata   data bus request (held during ACCESS)
//   d_ack/d_rdata        data bus completion and read data (same cycle)
//   misalign             one-cycle pulse for a dropped misaligned H/W access
//   rd_MEM/res_MEM       MEM register view for EX forwarding
//   rd_WB/res_WB         writeback register pair
module mem_stage #(
    parameter logic [6:0] LOAD_OPC  = 7'b0000011,
    parameter logic [6:0] STORE_OPC = 7'b0100011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode_EX,
    input  logic [2:0]  funct3_EX,
    input  logic [4:0]  rd_EX,
    input  logic [31:0] res_EX,
    input  logic [31:0] x2_EX,
    input  logic        trap_EX,
    output logic        stall,
    output logic        d_req,
    output logic        d_we,
    output logic [31:0] d_addr,
    output logic [3:0]  d_be,
    output logic [31:0] d_wdata,
    input  logic        d_ack,
    input  logic [31:0] d_rdata,
    output logic        misalign,
    output logic [4:0]  rd_MEM,
    output logic [31:0] res_MEM,
    output logic [4:0]  rd_WB,
    output logic [31:0] res_WB
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_q;
    logic        m_load_q;
    logic        m_mem_q;
    logic [2:0]  m_f3_q;
    logic [4:0]  m_rd_q;
    logic [31:0] m_res_q;
    logic [4:0]  rd_mem_q;
    logic        misalign_q;
    logic        d_req_q;
    logic        d_we_q;
    logic [31:0] d_addr_q;
    logic [3:0]  d_be_q;
    logic [31:0] d_wdata_q;
    logic [4:0]  rd_wb_q;
    logic [31:0] res_wb_q;

    // EX-side decode; a trapped instruction is never treated as a memory op
    logic        ex_load;
    logic        ex_store;
    logic        ex_mem;
    logic [1:0]  ex_a;
    logic        ex_misal;
    logic        ex_access;
    logic [3:0]  ex_be_d;
    logic [31:0] ex_wdata_d;
    logic [31:0] lane;
    logic [31:0] ld_ext;

    assign ex_load  = ~trap_EX & (opcode_EX == LOAD_OPC);
    assign ex_store = ~trap_EX & (opcode_EX == STORE_OPC);
    assign ex_mem   = ex_load | ex_store;
    assign ex_a     = res_EX[1:0];

    // funct3[1:0]: 00 byte, 01 half, anything else is a word access
    assign ex_misal  = ex_mem & (((funct3_EX[1:0] == 2'b01) & ex_a[0]) |
                                 (funct3_EX[1] & (ex_a != 2'b00)));
    assign ex_access = ex_mem & ~ex_misal;

    always_comb begin
        ex_be_d    = 4'b1111;
        ex_wdata_d = x2_EX;
        case (funct3_EX[1:0])
            2'b00: begin
                ex_be_d    = 4'b0001 << ex_a;
                ex_wdata_d = {4{x2_EX[7:0]}};
            end
            2'b01: begin
                ex_be_d    = ex_a[1] ? 4'b1100 : 4'b0011;
                ex_wdata_d = {2{x2_EX[15:0]}};
            end
            default: begin
                ex_be_d    = 4'b1111;
                ex_wdata_d = x2_EX;
            end
        endcase
    end

    // Read data: shift the addressed lane down to bit 0, then extend
    assign lane = d_rdata >> {m_res_q[1:0], 3'b000};

    always_comb begin
        ld_ext = d_rdata;
        case (m_f3_q)
            3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ld_ext = {24'd0, lane[7:0]};
            3'b101:  ld_ext = {16'd0, lane[15:0]};
            default: ld_ext = d_rdata;
        endcase
    end

    // A zero-wait ack never stalls; each missing ack cycle costs one stall
    assign stall = (state_q == ACCESS) & ~d_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            m_load_q   <= 1'b0;
            m_mem_q    <= 1'b0;
            m_f3_q     <= 3'd0;
            m_rd_q     <= 5'd0;
            m_res_q    <= 32'd0;
            rd_mem_q   <= 5'd0;
            misalign_q <= 1'b0;
            d_req_q    <= 1'b0;
            d_we_q     <= 1'b0;
            d_addr_q   <= 32'd0;
            d_be_q     <= 4'd0;
            d_wdata_q  <= 32'd0;
            rd_wb_q    <= 5'd0;
            res_wb_q   <= 32'd0;
        end else if (!stall) begin
            // Retire the instruction currently in MEM into WB
            if (state_q == ACCESS) begin
                // Not stalled in ACCESS means d_ack is high this cycle
                if (m_load_q) begin
                    rd_wb_q  <= m_rd_q;
                    res_wb_q <= ld_ext;
                end else begin
                    rd_wb_q  <= 5'd0;
                end
            end else if (m_mem_q) begin
                // Misaligned access reached here without a bus cycle
                rd_wb_q <= 5'd0;
            end else begin
                rd_wb_q  <= m_rd_q;
                res_wb_q <= m_res_q;
            end

            // Capture the next instruction from EX
            m_load_q   <= ex_load;
            m_mem_q    <= ex_mem;
            m_f3_q     <= funct3_EX;
            m_rd_q     <= trap_EX ? 5'd0 : rd_EX;
            m_res_q    <= trap_EX ? 32'd0 : res_EX;
            // Addresses must never be forwarded as results
            rd_mem_q   <= (trap_EX | ex_mem) ? 5'd0 : rd_EX;
            misalign_q <= ex_misal;
            state_q    <= ex_access ? ACCESS : IDLE;
            d_req_q    <= ex_access;
            d_we_q     <= ex_access & ex_store;
            d_addr_q   <= ex_access ? {res_EX[31:2], 2'b00} : 32'd0;
            d_be_q     <= ex_access ? ex_be_d : 4'd0;
            d_wdata_q  <= ex_access ? ex_wdata_d : 32'd0;
        end else begin
            // Waiting on the bus: hold MEM and the request, keep WB empty
            rd_wb_q    <= 5'd0;
            misalign_q <= 1'b0;
        end
    end

    assign d_req    = d_req_q;
    assign d_we     = d_we_q;
    assign d_addr   = d_addr_q;
    assign d_be     = d_be_q;
    assign d_wdata  = d_wdata_q;
    assign misalign = misalign_q;
    assign rd_MEM   = rd_mem_q;
    assign res_MEM  = m_res_q;
    assign rd_WB    = rd_wb_q;
    assign res_WB   = res_wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] ALU = 7'b0110011;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode_EX;
    logic [2:0]  funct3_EX;
    logic [4:0]  rd_EX;
    logic [31:0] res_EX;
    logic [31:0] x2_EX;
    logic        trap_EX;
    logic        stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        misalign;
    logic [4:0]  rd_MEM;
    logic [31:0] res_MEM;
    logic [4:0]  rd_WB;
    logic [31:0] res_WB;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .opcode_EX(opcode_EX), .funct3_EX(funct3_EX), .rd_EX(rd_EX),
        .res_EX(res_EX), .x2_EX(x2_EX), .trap_EX(trap_EX),
        .stall(stall), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_be(d_be), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .misalign(misalign), .rd_MEM(rd_MEM), .res_MEM(res_MEM),
        .rd_WB(rd_WB), .res_WB(res_WB)
    );

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] x2;
        logic        trap;
        int          waits;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_mis;
        logic [4:0]  e_rdwb;
        logic [31:0] e_reswb;
        logic [4:0]  e_rdmem;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%h required=0x%h", name, act, req);
        end
    endtask

    function automatic void add(
        input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
        input logic [31:0] res, input logic [31:0] x2, input logic trap,
        input int waits, input logic [31:0] rdata, input logic e_req,
        input logic e_we, input logic [3:0] e_be, input logic [31:0] e_wdata,
        input logic e_mis, input logic [4:0] e_rdwb, input logic [31:0] e_reswb,
        input logic [4:0] e_rdmem);
        vec_t v;
        v.opc = opc; v.f3 = f3; v.rd = rd; v.res = res; v.x2 = x2; v.trap = trap;
        v.waits = waits; v.rdata = rdata; v.e_req = e_req; v.e_we = e_we;
        v.e_be = e_be; v.e_wdata = e_wdata; v.e_mis = e_mis; v.e_rdwb = e_rdwb;
        v.e_reswb = e_reswb; v.e_rdmem = e_rdmem;
        tbl.push_back(v);
    endfunction

    task automatic drive_ex(input vec_t v);
        opcode_EX = v.opc; funct3_EX = v.f3; rd_EX = v.rd;
        res_EX = v.res; x2_EX = v.x2; trap_EX = v.trap;
    endtask

    initial begin
        vec_t   mem_v;
        vec_t   e;
        logic   mem_valid;
        logic   st;
        int     idx;
        int     wcnt;
        int     stall_cnt;
        int     cycles;
        logic [31:0] held_addr;

        //  opc  f3    rd  res           x2            tr w  rdata         req we be       wdata         mis rdwb reswb        rdmem
        add(ALU, 3'd0, 5,  32'h7,        32'h0,        0, 0, 32'h0,        0,  0, 4'h0,    32'h0,        0,  5,   32'h7,        5);
        add(ST,  3'd2, 0,  32'h100,      32'hDEADBEEF, 0, 0, 32'h0,        1,  1, 4'b1111, 32'hDEADBEEF, 0,  0,   32'h0,        0);
        add(ST,  3'd1, 0,  32'h102,      32'h00001234, 0, 0, 32'h0,        1,  1, 4'b1100, 32'h12341234, 0,  0,   32'h0,        0);
        add(LD,  3'd0, 6,  32'h103,      32'h0,        0, 0, 32'h80FF0000, 1,  0, 4'b1000, 32'h0,        0,  6,   32'hFFFFFF80, 0);
        add(LD,  3'd4, 7,  32'h103,      32'h0,        0, 0, 32'h80FF0000, 1,  0, 4'b1000, 32'h0,        0,  7,   32'h00000080, 0);
        add(LD,  3'd2, 8,  32'h40,       32'h0,        0, 3, 32'h12345678, 1,  0, 4'b1111, 32'h0,        0,  8,   32'h12345678, 0);
        add(LD,  3'd1, 9,  32'h101,      32'h0,        0, 0, 32'h0,        0,  0, 4'h0,    32'h0,        1,  0,   32'h0,        0);
        add(LD,  3'd1, 10, 32'h102,      32'h0,        0, 0, 32'hBEEF0000, 1,  0, 4'b1100, 32'h0,        0,  10,  32'hFFFFBEEF, 0);
        add(LD,  3'd5, 11, 32'h102,      32'h0,        0, 1, 32'hBEEF0000, 1,  0, 4'b1100, 32'h0,        0,  11,  32'h0000BEEF, 0);
        add(ALU, 3'd0, 12, 32'd99,       32'h0,        1, 0, 32'h0,        0,  0, 4'h0,    32'h0,        0,  0,   32'h0,        0);
        add(ST,  3'd0, 0,  32'h201,      32'h000000AB, 0, 0, 32'h0,        1,  1, 4'b0010, 32'hABABABAB, 0,  0,   32'h0,        0);
        add(LD,  3'd2, 13, 32'h42,       32'h0,        0, 0, 32'h0,        0,  0, 4'h0,    32'h0,        1,  0,   32'h0,        0);
        add(LD,  3'd3, 14, 32'h44,       32'h0,        0, 0, 32'hCAFEF00D, 1,  0, 4'b1111, 32'h0,        0,  14,  32'hCAFEF00D, 0);
        add(LD,  3'd0, 15, 32'h100,      32'h0,        0, 2, 32'h1234567F, 1,  0, 4'b0001, 32'h0,        0,  15,  32'h0000007F, 0);
        add(ALU, 3'd0, 16, 32'hA5A5A5A5, 32'h0,        0, 0, 32'h0,        0,  0, 4'h0,    32'h0,        0,  16,  32'hA5A5A5A5, 16);
        add(ST,  3'd2, 0,  32'h300,      32'h11111111, 1, 0, 32'h0,        0,  0, 4'h0,    32'h0,        0,  0,   32'h0,        0);
        add(7'd0, 3'd0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0,  0, 4'h0,    32'h0,        0,  0,   32'h0,        0);
        add(7'd0, 3'd0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0,  0, 4'h0,    32'h0,        0,  0,   32'h0,        0);

        // Reset state
        reset = 1'b1; d_ack = 1'b0; d_rdata = 32'h0;
        drive_ex(tbl[tbl.size()-1]);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_d_req", {31'd0, d_req}, 32'd0);
        chk("rst_d_we", {31'd0, d_we}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rd_MEM", {27'd0, rd_MEM}, 32'd0);
        chk("rst_rd_WB", {27'd0, rd_WB}, 32'd0);
        chk("rst_res_MEM", res_MEM, 32'd0);
        chk("rst_res_WB", res_WB, 32'd0);
        chk("rst_d_addr", d_addr, 32'd0);
        chk("rst_d_be", {28'd0, d_be}, 32'd0);
        chk("rst_d_wdata", d_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven stream with a bus responder and WB scoreboard
        mem_valid = 1'b0; idx = 0; wcnt = 0; stall_cnt = 0; cycles = 0;
        held_addr = 32'h0;
        mem_v = tbl[0];
        while (idx < tbl.size()) begin
            if (cycles > 2000) begin
                chk("stream_timeout", idx, tbl.size());
                break;
            end
            cycles++;
            if (cycles > 1) @(negedge clk);
            if (mem_valid && d_req) begin
                if (wcnt == mem_v.waits) begin
                    d_ack = 1'b1; d_rdata = mem_v.rdata;
                end else begin
                    d_ack = 1'b0; d_rdata = 32'h0; wcnt++;
                end
            end else begin
                d_ack = 1'b0; d_rdata = 32'h0;
            end
            drive_ex(tbl[idx]);
            #1;
            st = stall;
            @(posedge clk);
            #1;
            if (st) begin
                stall_cnt++;
                chk($sformatf("stall_wb_bubble[%0d]", idx), {27'd0, rd_WB}, 32'd0);
                chk($sformatf("stall_req_held[%0d]", idx), {31'd0, d_req}, 32'd1);
                chk($sformatf("stall_addr_held[%0d]", idx), d_addr, held_addr);
            end else begin
                if (mem_valid) begin
                    e = exp_q.pop_front();
                    chk($sformatf("stall_cycles[%0d]", idx - 1), stall_cnt,
                        e.e_req ? e.waits : 0);
                    chk($sformatf("rd_WB[%0d]", idx - 1), {27'd0, rd_WB}, {27'd0, e.e_rdwb});
                    if (e.e_rdwb != 5'd0)
                        chk($sformatf("res_WB[%0d]", idx - 1), res_WB, e.e_reswb);
                end
                mem_v = tbl[idx];
                exp_q.push_back(mem_v);
                mem_valid = 1'b1; wcnt = 0; stall_cnt = 0;
                held_addr = d_addr;
                chk($sformatf("d_req[%0d]", idx), {31'd0, d_req}, {31'd0, mem_v.e_req});
                chk($sformatf("misalign[%0d]", idx), {31'd0, misalign}, {31'd0, mem_v.e_mis});
                chk($sformatf("rd_MEM[%0d]", idx), {27'd0, rd_MEM}, {27'd0, mem_v.e_rdmem});
                if (mem_v.e_rdmem != 5'd0)
                    chk($sformatf("res_MEM[%0d]", idx), res_MEM, mem_v.res);
                if (mem_v.e_req) begin
                    chk($sformatf("d_we[%0d]", idx), {31'd0, d_we}, {31'd0, mem_v.e_we});
                    chk($sformatf("d_addr[%0d]", idx), d_addr, {mem_v.res[31:2], 2'b00});
                    chk($sformatf("d_be[%0d]", idx), {28'd0, d_be}, {28'd0, mem_v.e_be});
                    if (mem_v.e_we)
                        chk($sformatf("d_wdata[%0d]", idx), d_wdata, mem_v.e_wdata);
                end
                idx++;
            end
        end

        // Reset while an access is waiting for ack
        @(negedge clk);
        d_ack = 1'b0;
        opcode_EX = LD; funct3_EX = 3'd2; rd_EX = 5'd3; res_EX = 32'h80;
        x2_EX = 32'h0; trap_EX = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_d_req", {31'd0, d_req}, 32'd1);
        @(negedge clk);
        chk("pre_rst_stall", {31'd0, stall}, 32'd1);
        opcode_EX = 7'd0; rd_EX = 5'd0; res_EX = 32'h0;
        reset = 1'b1; d_ack = 1'b1; d_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        chk("rst_access_d_req", {31'd0, d_req}, 32'd0);
        chk("rst_access_rd_WB", {27'd0, rd_WB}, 32'd0);
        chk("rst_access_res_WB", res_WB, 32'd0);
        @(negedge clk);
        reset = 1'b0; d_ack = 1'b0; d_rdata = 32'h0;
        #1;
        chk("rst_access_idle", {31'd0, stall}, 32'd0);

        // After reset a plain ALU op flows straight through
        opcode_EX = ALU; rd_EX = 5'd21; res_EX = 32'h55AA;
        @(posedge clk); #1;
        chk("post_rst_rd_MEM", {27'd0, rd_MEM}, 32'd21);
        @(negedge clk);
        opcode_EX = 7'd0; rd_EX = 5'd0; res_EX = 32'h0;
        @(posedge clk); #1;
        chk("post_rst_rd_WB", {27'd0, rd_WB}, 32'd21);
        chk("post_rst_res_WB", res_WB, 32'h55AA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
